// File: rtl/screen_draw_sequencer_pkg.sv
// Shared frame geometry, screen codes and FSM encoding for the
// full-frame background draw sequencer.
package screen_draw_sequencer_pkg;

    localparam int X_MAX_DEF    = 159;
    localparam int Y_MAX_DEF    = 119;
    localparam int ADDR_W_DEF   = 15;
    localparam int COLOR_W_DEF  = 3;
    localparam int SEL_W        = 3;
    localparam int FRAME_PIXELS = (X_MAX_DEF + 1) * (Y_MAX_DEF + 1);

    // Same codes as the screen/home FSM glue and chooseBackgroundMux
    typedef enum logic [SEL_W-1:0] {
        SCR_SLOW   = 3'b000,
        SCR_NORMAL = 3'b001,
        SCR_FAST   = 3'b010,
        SCR_GAME   = 3'b011,
        SCR_OVER   = 3'b100
    } screen_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/screen_draw_sequencer_if.sv
// Sequencer bundle: draw request in, ROM address/data and
// aligned adapter pixel stream out.
interface screen_draw_sequencer_if
    import screen_draw_sequencer_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int COLOR_W = COLOR_W_DEF
) ();

    logic               start;
    logic [SEL_W-1:0]   screen_sel;
    logic [SEL_W-1:0]   sel_q;
    logic [ADDR_W-1:0]  rom_addr;
    logic [COLOR_W-1:0] rom_color;
    logic [7:0]         vga_x;
    logic [6:0]         vga_y;
    logic [COLOR_W-1:0] vga_colour;
    logic               plot;
    logic               busy;
    logic               done;

    modport master (
        input  start, screen_sel, rom_color,
        output sel_q, rom_addr, vga_x, vga_y, vga_colour,
        output plot, busy, done
    );

    modport slave (
        output start, screen_sel, rom_color,
        input  sel_q, rom_addr, vga_x, vga_y, vga_colour,
        input  plot, busy, done
    );

endinterface

// File: rtl/screen_draw_sequencer_pixel_wrap_counter.sv
// Up-counter 0..MAX with synchronous clear and a wrap flag that
// is high while enabled at MAX.
module screen_draw_sequencer_pixel_wrap_counter #(
    parameter int W   = 8,
    parameter int MAX = 159
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] MaxV = W'(MAX);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = (count_q == MaxV) ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = en_i && (count_q == MaxV);

endmodule

// File: rtl/screen_draw_sequencer.sv
// Bounded row-major raster walk over the background ROM with
// 1-cycle ROM latency alignment and busy/done reporting.
module screen_draw_sequencer
    import screen_draw_sequencer_pkg::*;
#(
    parameter int X_MAX  = X_MAX_DEF,
    parameter int Y_MAX  = Y_MAX_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                    CLOCK_50,
    input  logic                    Resetn,
    screen_draw_sequencer_if.master bus
);

    localparam int XW = $clog2(X_MAX + 1);
    localparam int YW = $clog2(Y_MAX + 1);

    state_e            state_q, state_d;
    logic              fetch, start_go;
    logic              x_wrap, last;
    logic [XW-1:0]     x_cnt, vx_q;
    logic [YW-1:0]     y_cnt, vy_q;
    logic              plot_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [SEL_W-1:0]  sel_q, sel_d;

    // y only advances on an x wrap, so its wrap flag marks the final pixel
    screen_draw_sequencer_pixel_wrap_counter #(.W(XW), .MAX(X_MAX)) u_x (
        .clk_i   (CLOCK_50),
        .rst_ni  (Resetn),
        .en_i    (fetch),
        .clr_i   (start_go),
        .count_o (x_cnt),
        .wrap_o  (x_wrap)
    );

    screen_draw_sequencer_pixel_wrap_counter #(.W(YW), .MAX(Y_MAX)) u_y (
        .clk_i   (CLOCK_50),
        .rst_ni  (Resetn),
        .en_i    (x_wrap),
        .clr_i   (start_go),
        .count_o (y_cnt),
        .wrap_o  (last)
    );

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_FETCH;
            ST_FETCH: if (last) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fetch    = (state_q == ST_FETCH);
        start_go = (state_q == ST_IDLE) && bus.start;
        bus.busy = (state_q != ST_IDLE);
        bus.done = (state_q == ST_DONE);
    end

    always_comb begin
        addr_d = addr_q;
        sel_d  = sel_q;
        if (start_go) begin
            addr_d = '0;
            sel_d  = bus.screen_sel;
        end else if (fetch && !last) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            addr_q <= '0;
            sel_q  <= '0;
            plot_q <= 1'b0;
            vx_q   <= '0;
            vy_q   <= '0;
        end else begin
            addr_q <= addr_d;
            sel_q  <= sel_d;
            plot_q <= fetch;
            if (fetch) begin
                vx_q <= x_cnt;
                vy_q <= y_cnt;
            end
        end
    end

    assign bus.rom_addr   = addr_q;
    assign bus.sel_q      = sel_q;
    assign bus.plot       = plot_q;
    assign bus.vga_x      = 8'(vx_q);
    assign bus.vga_y      = 7'(vy_q);
    assign bus.vga_colour = bus.rom_color;

endmodule

// File: tb/tb_screen_draw_sequencer.sv
// Self-checking bench: vector table, randomized frames against
// a cycle-offset reference model, reset and back-to-back cases.
module tb_screen_draw_sequencer;
    import screen_draw_sequencer_pkg::*;

    localparam int W      = 160;
    localparam int NPIX   = FRAME_PIXELS;
    localparam int K_DONE = NPIX + 2;

    logic CLOCK_50 = 1'b0;
    logic Resetn   = 1'b0;

    screen_draw_sequencer_if bus ();

    screen_draw_sequencer dut (
        .CLOCK_50 (CLOCK_50),
        .Resetn   (Resetn),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // ROM with one cycle of latency returning addr[2:0]
    always @(posedge CLOCK_50) bus.rom_color <= bus.rom_addr[2:0];

    int total = 0;
    int bad   = 0;
    int nplot = 0;
    int ndone = 0;

    // Model: m_k counts cycles since the accepting edge (1 = first)
    bit         m_act   = 0;
    int         m_k     = 0;
    logic [2:0] m_sel   = 3'b000;
    bit         m_fresh = 1;

    typedef struct {
        logic        st;
        logic [2:0]  sel;
        logic        busy;
        logic        plot;
        logic [2:0]  selq;
        logic [14:0] addr;
    } vec_t;

    vec_t tv[5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (k=%0d)", name, act, exp, m_k);
        end
    endtask

    task automatic model_reset();
        m_act   = 0;
        m_k     = 0;
        m_sel   = 3'b000;
        m_fresh = 1;
    endtask

    task automatic model_edge(input logic st, input logic [2:0] sel);
        bit idle;
        if (!Resetn) begin
            model_reset();
        end else begin
            idle = !m_act || (m_k > K_DONE);
            if (idle && st) begin
                m_act   = 1;
                m_k     = 1;
                m_sel   = sel;
                m_fresh = 0;
            end else if (m_act) begin
                m_k++;
            end
        end
    endtask

    task automatic check_cycle();
        bit plot_e;
        int p;
        plot_e = m_act && (m_k >= 2) && (m_k <= NPIX + 1);
        chk("busy", 32'(bus.busy), 32'(m_act && m_k <= K_DONE));
        chk("done", 32'(bus.done), 32'(m_act && m_k == K_DONE));
        chk("plot", 32'(bus.plot), 32'(plot_e));
        chk("sel_q", 32'(bus.sel_q), 32'(m_sel));
        if (m_fresh) begin
            chk("addr_rst", 32'(bus.rom_addr), 0);
            chk("x_rst", 32'(bus.vga_x), 0);
            chk("y_rst", 32'(bus.vga_y), 0);
        end
        if (m_act && m_k <= NPIX)
            chk("rom_addr", 32'(bus.rom_addr), 32'(m_k - 1));
        if (plot_e) begin
            p = m_k - 2;
            chk("vga_x", 32'(bus.vga_x), 32'(p % W));
            chk("vga_y", 32'(bus.vga_y), 32'(p / W));
            chk("colour", 32'(bus.vga_colour), 32'(p % 8));
        end
        if (bus.plot === 1'b1) nplot++;
        if (bus.done === 1'b1) ndone++;
    endtask

    task automatic step(input logic st, input logic [2:0] sel);
        bus.start      = st;
        bus.screen_sel = sel;
        @(posedge CLOCK_50);
        model_edge(st, sel);
        @(negedge CLOCK_50);
        check_cycle();
    endtask

    function automatic logic [2:0] rsel();
        return 3'($urandom_range(0, 4));
    endfunction

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int busy_low;
        int d0;

        tv[0] = '{1'b0, 3'b011, 1'b0, 1'b0, 3'b000, 15'd0};
        tv[1] = '{1'b1, 3'b011, 1'b1, 1'b0, 3'b011, 15'd0};
        tv[2] = '{1'b0, 3'b100, 1'b1, 1'b1, 3'b011, 15'd1};
        tv[3] = '{1'b1, 3'b010, 1'b1, 1'b1, 3'b011, 15'd2};
        tv[4] = '{1'b0, 3'b000, 1'b1, 1'b1, 3'b011, 15'd3};

        bus.start      = 1'b0;
        bus.screen_sel = 3'b000;
        repeat (3) @(negedge CLOCK_50);
        check_cycle();
        Resetn = 1'b1;

        // Frame 1: table for the opening cycles
        for (int i = 0; i < 5; i++) begin
            step(tv[i].st, tv[i].sel);
            chk("tv_busy", 32'(bus.busy), 32'(tv[i].busy));
            chk("tv_plot", 32'(bus.plot), 32'(tv[i].plot));
            chk("tv_selq", 32'(bus.sel_q), 32'(tv[i].selq));
            chk("tv_addr", 32'(bus.rom_addr), 32'(tv[i].addr));
        end
        chk("tv_x0", 32'(bus.vga_x), 2);

        // Rest of frame 1 with random ignored starts
        guard = 0;
        nplot = 3;
        ndone = 0;
        while (!(m_act && m_k == K_DONE + 1) && guard < 20000) begin
            guard++;
            if (m_k == 500 || m_k == K_DONE)
                step(1'b1, 3'b100);
            else if (m_k > K_DONE)
                step(1'b0, rsel());
            else
                step(1'($urandom_range(0, 3) == 0), rsel());
            if (m_k == 160)
                chk("wrap_addr159", 32'(bus.rom_addr), 159);
            if (m_k == 161) begin
                chk("wrap_addr160", 32'(bus.rom_addr), 160);
                chk("wrap_x159", 32'(bus.vga_x), 159);
                chk("wrap_y0", 32'(bus.vga_y), 0);
            end
            if (m_k == 162) begin
                chk("wrap_x0", 32'(bus.vga_x), 0);
                chk("wrap_y1", 32'(bus.vga_y), 1);
            end
            if (m_k == NPIX + 1) begin
                chk("last_x", 32'(bus.vga_x), 159);
                chk("last_y", 32'(bus.vga_y), 119);
            end
        end
        chk("f1_bound", 32'(guard < 20000), 1);
        chk("f1_busy_low", 32'(bus.busy), 0);
        chk("f1_plots", 32'(nplot), 32'(NPIX));
        chk("f1_dones", 32'(ndone), 1);
        chk("f1_sel_kept", 32'(bus.sel_q), 32'(3'b011));

        // Reset mid-frame at cycle 10000
        step(1'b0, 3'b001);
        step(1'b1, 3'b001);
        while (m_k < 10000) step(1'($urandom_range(0, 1)), rsel());
        d0 = ndone;
        #2;
        Resetn = 1'b0;
        model_reset();
        #1;
        chk("arst_plot", 32'(bus.plot), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_done", 32'(bus.done), 0);
        chk("arst_addr", 32'(bus.rom_addr), 0);
        step(1'b1, 3'b010);
        step(1'b1, 3'b010);
        Resetn = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0, rsel());
        chk("rst_no_done", 32'(ndone), 32'(d0));
        step(1'b1, 3'b010);
        while (m_k < 400) begin
            step(1'($urandom_range(0, 1)), rsel());
            if (m_k == 2) begin
                chk("redraw_plot", 32'(bus.plot), 1);
                chk("redraw_x", 32'(bus.vga_x), 0);
                chk("redraw_y", 32'(bus.vga_y), 0);
            end
        end

        // Back-to-back redraw with start held high
        #2;
        Resetn = 1'b0;
        model_reset();
        step(1'b0, 3'b000);
        Resetn = 1'b1;
        step(1'b0, 3'b000);
        step(1'b1, 3'b000);
        busy_low = 0;
        for (int n = 2; n <= 19500; n++) begin
            step(1'b1, rsel());
            if (bus.busy !== 1'b1) busy_low++;
            if (n == 19202) chk("b2b_done", 32'(bus.done), 1);
            if (n == 19203) chk("b2b_idle", 32'(bus.busy), 0);
            if (n == 19204) chk("b2b_busy", 32'(bus.busy), 1);
            if (n == 19205) begin
                chk("b2b_plot", 32'(bus.plot), 1);
                chk("b2b_x", 32'(bus.vga_x), 0);
                chk("b2b_y", 32'(bus.vga_y), 0);
            end
        end
        chk("b2b_busy_low", 32'(busy_low), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
